// File: rtl/marker_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : marker_display_ctrl
// Description : Latches a (column, row) marker position on a load strobe and
//               drives an up/down circle on the selected digit of an N-digit
//               active-low 7-segment bank. The marker can blink. A clear
//               strobe blanks the bank. An out-of-range column gives a timed
//               blinking-dash error indication.
//
// Ports       : clk_i        system clock, rising edge
//               rst_i        synchronous active-high reset
//               load_i       one-cycle strobe, samples col_i / row_i
//               col_i        marker column (digit index, 0 = digit 0)
//               row_i        1 = upper circle, 0 = lower circle
//               blink_en_i   1 = marker blinks while shown
//               clear_i      one-cycle strobe, blank and forget position
//               hex_o        digit k at [8k+7:8k], bit7 = dp, active low
//               err_o        high while the error indication is active
//               pos_valid_o  high while a valid position is held
//
// Revision    : 1.0 - initial release
// ============================================================================
module marker_display_ctrl #(
    parameter int N_DIGITS    = 6,
    parameter int COL_W       = 3,
    parameter int BLINK_DIV   = 25000000,
    parameter int ERR_TOGGLES = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [COL_W-1:0]      col_i,
    input  logic                  row_i,
    input  logic                  blink_en_i,
    input  logic                  clear_i,
    output logic [N_DIGITS*8-1:0] hex_o,
    output logic                  err_o,
    output logic                  pos_valid_o
);

    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam int ERR_W = $clog2(ERR_TOGGLES + 1);

    localparam logic [1:0] c_ST_BLANK = 2'd0;
    localparam logic [1:0] c_ST_SHOW  = 2'd1;
    localparam logic [1:0] c_ST_ERROR = 2'd2;

    localparam logic [7:0] c_SEG_UP    = 8'b1001_1100;
    localparam logic [7:0] c_SEG_DOWN  = 8'b1010_0011;
    localparam logic [7:0] c_SEG_DASH  = 8'b1011_1111;
    localparam logic [7:0] c_SEG_BLANK = 8'b1111_1111;

    localparam logic [CNT_W-1:0] c_CNT_MAX      = CNT_W'(BLINK_DIV - 1);
    localparam logic [ERR_W-1:0] c_ERR_INIT     = ERR_W'(ERR_TOGGLES);
    localparam logic [ERR_W-1:0] c_ERR_LAST     = ERR_W'(1);
    // One extra bit so that N_DIGITS == 2**COL_W is representable.
    localparam logic [COL_W:0]   c_N_DIGITS_EXT = (COL_W + 1)'(N_DIGITS);

    logic [1:0]       r_state;
    logic [COL_W-1:0] r_col;
    logic             r_row;
    logic             r_pos_valid;
    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_phase;
    logic [ERR_W-1:0] r_err_cnt;

    logic w_col_ok;
    logic w_wrap;

    // Columns are never folded: any code at or above N_DIGITS is an error.
    assign w_col_ok = ({1'b0, col_i} < c_N_DIGITS_EXT);
    assign w_wrap   = (r_blink_cnt == c_CNT_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_BLANK;
            r_col       <= '0;
            r_row       <= 1'b0;
            r_pos_valid <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_err_cnt   <= '0;
        end else if (clear_i) begin
            r_state     <= c_ST_BLANK;
            r_pos_valid <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_err_cnt   <= '0;
        end else if (load_i) begin
            // A load always restarts the timer, so a load landing on a
            // wrap edge suppresses that toggle and decrement.
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            if (w_col_ok) begin
                r_state     <= c_ST_SHOW;
                r_col       <= col_i;
                r_row       <= row_i;
                r_pos_valid <= 1'b1;
            end else begin
                r_state   <= c_ST_ERROR;
                r_err_cnt <= c_ERR_INIT;
            end
        end else begin
            case (r_state)
                c_ST_SHOW: begin
                    if (blink_en_i) begin
                        if (w_wrap) begin
                            r_blink_cnt <= '0;
                            r_phase     <= ~r_phase;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + 1'b1;
                        end
                    end else begin
                        // Steady marker: the next enable starts a fresh
                        // visible half-period.
                        r_blink_cnt <= '0;
                        r_phase     <= 1'b1;
                    end
                end
                c_ST_ERROR: begin
                    if (w_wrap) begin
                        r_blink_cnt <= '0;
                        if (r_err_cnt == c_ERR_LAST) begin
                            r_err_cnt <= '0;
                            r_phase   <= 1'b1;
                            r_state   <= r_pos_valid ? c_ST_SHOW : c_ST_BLANK;
                        end else begin
                            r_err_cnt <= r_err_cnt - 1'b1;
                            r_phase   <= ~r_phase;
                        end
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end
                c_ST_BLANK: begin
                    r_blink_cnt <= '0;
                    r_phase     <= 1'b1;
                end
                default: begin
                    r_state     <= c_ST_BLANK;
                    r_blink_cnt <= '0;
                    r_phase     <= 1'b1;
                    r_err_cnt   <= '0;
                end
            endcase
        end
    end

    // Output decode is purely combinational from registered state.
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        logic w_sel;
        assign w_sel = (r_state == c_ST_SHOW) && r_phase && (r_col == COL_W'(k));
        assign hex_o[8*k +: 8] =
            (r_state == c_ST_ERROR) ? (r_phase ? c_SEG_DASH : c_SEG_BLANK) :
            w_sel                   ? (r_row ? c_SEG_UP : c_SEG_DOWN)      :
                                      c_SEG_BLANK;
    end

    assign err_o       = (r_state == c_ST_ERROR);
    assign pos_valid_o = r_pos_valid;

endmodule
`default_nettype wire
